// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD capture path: FSM encoding and the default
// synthetic geometry that the driver and benches agree on.
package lcd_pkg;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam int H_ACTIVE = 4;
  localparam int H_TOTAL  = 8;
  localparam int V_ACTIVE = 3;

endpackage

// File: rtl/lcd_sync_edge.sv
// Input register for the LCD pins: normalises sync polarity to active-high
// and derives one-cycle leading/trailing edge strobes from the registered copy.
module lcd_sync_edge #(
  parameter int DATA_W    = 8,
  parameter bit HSYNC_ACT = 1'b0,
  parameter bit VSYNC_ACT = 1'b0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [DATA_W-1:0] lcd_dat,
  input  logic              lcd_hsync,
  input  logic              lcd_vsync,
  input  logic              lcd_den,
  output logic [DATA_W-1:0] dat,
  output logic              den,
  output logic              vs_lead,
  output logic              hs_lead,
  output logic              den_rise,
  output logic              den_fall
);

  logic hs_q, vs_q, hs_prev, vs_prev, den_prev;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dat      <= '0;
      den      <= 1'b0;
      hs_q     <= 1'b0;
      vs_q     <= 1'b0;
      hs_prev  <= 1'b0;
      vs_prev  <= 1'b0;
      den_prev <= 1'b0;
    end else begin
      dat      <= lcd_dat;
      den      <= lcd_den;
      hs_q     <= (lcd_hsync == HSYNC_ACT);
      vs_q     <= (lcd_vsync == VSYNC_ACT);
      hs_prev  <= hs_q;
      vs_prev  <= vs_q;
      den_prev <= den;
    end
  end

  assign vs_lead  = vs_q & ~vs_prev;
  assign hs_lead  = hs_q & ~hs_prev;
  assign den_rise = den & ~den_prev;
  assign den_fall = ~den & den_prev;

endmodule

// File: rtl/lcd_capture.sv
// Receive side of the parallel LCD link: recovers a pixel stream with x/y and
// frame markers, measures frame geometry and locks after two matching frames.
module lcd_capture
  import lcd_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int XW        = 11,
  parameter int YW        = 10,
  parameter bit HSYNC_ACT = 1'b0,
  parameter bit VSYNC_ACT = 1'b0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [DATA_W-1:0] lcd_dat,
  input  logic              lcd_hsync,
  input  logic              lcd_vsync,
  input  logic              lcd_den,
  output logic [DATA_W-1:0] pix_dat,
  output logic              pix_valid,
  output logic              pix_sof,
  output logic              pix_eol,
  output logic [XW-1:0]     pix_x,
  output logic [YW-1:0]     pix_y,
  output logic [XW-1:0]     meas_width,
  output logic [YW-1:0]     meas_height,
  output logic [XW-1:0]     meas_htotal,
  output logic              locked,
  output logic              err_geom,
  output logic [15:0]       frame_cnt
);

  localparam logic [XW-1:0] X_MAX = {XW{1'b1}};
  localparam logic [YW-1:0] Y_MAX = {YW{1'b1}};

  logic [DATA_W-1:0] dat_s1;
  logic              den_s1, vs_lead, hs_lead, den_rise, den_fall;

  state_t        state, state_nx;
  logic          latch, set_err, active;
  logic [XW-1:0] run_len, line_w, hcnt, frame_w;
  logic [YW-1:0] line_cnt, frame_h;
  logic          mism, skip_run, sof_pend, hs_seen;
  logic          trunc, run_end, frame_bad, geom_match;

  lcd_sync_edge #(
    .DATA_W   (DATA_W),
    .HSYNC_ACT(HSYNC_ACT),
    .VSYNC_ACT(VSYNC_ACT)
  ) u_sync (
    .clk      (clk),
    .resetn   (resetn),
    .lcd_dat  (lcd_dat),
    .lcd_hsync(lcd_hsync),
    .lcd_vsync(lcd_vsync),
    .lcd_den  (lcd_den),
    .dat      (dat_s1),
    .den      (den_s1),
    .vs_lead  (vs_lead),
    .hs_lead  (hs_lead),
    .den_rise (den_rise),
    .den_fall (den_fall)
  );

  // A run still open when vsync arrives is closed early and always counts as bad.
  assign trunc      = den_s1 & ~den_rise;
  assign run_end    = (den_fall & ~skip_run) | trunc;
  assign frame_w    = run_end ? run_len : line_w;
  assign frame_h    = (run_end && line_cnt != Y_MAX) ? line_cnt + YW'(1) : line_cnt;
  assign frame_bad  = mism | trunc | (run_end & (run_len != meas_width))
                    | (frame_h != meas_height);
  assign geom_match = (frame_w == meas_width) && (frame_h == meas_height)
                    && (frame_w != '0) && (frame_h != '0);
  assign active     = (state != SEARCH) | vs_lead;

  always_comb begin
    state_nx = state;
    latch    = 1'b0;
    set_err  = 1'b0;
    if (vs_lead) begin
      unique case (state)
        SEARCH:  state_nx = MEASURE;
        MEASURE: begin
          latch = 1'b1;
          if (geom_match) state_nx = LOCKED;
        end
        LOCKED: begin
          latch = 1'b1;
          if (frame_bad) begin
            state_nx = MEASURE;
            set_err  = 1'b1;
          end
        end
        default: state_nx = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= SEARCH;
    else         state <= state_nx;
  end

  assign locked  = (state == LOCKED);
  assign pix_eol = pix_valid & ~den_s1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pix_dat   <= '0;
      pix_valid <= 1'b0;
      pix_sof   <= 1'b0;
      pix_x     <= '0;
      pix_y     <= '0;
      sof_pend  <= 1'b0;
    end else begin
      pix_dat   <= dat_s1;
      pix_valid <= den_s1 & active;
      pix_sof   <= den_s1 & active & (vs_lead | sof_pend);
      if (vs_lead)     sof_pend <= ~den_s1;
      else if (den_s1) sof_pend <= 1'b0;
      if (den_rise)                      pix_x <= '0;
      else if (den_s1 && pix_x != X_MAX) pix_x <= pix_x + XW'(1);
      if (vs_lead)                         pix_y <= '0;
      else if (den_fall && pix_y != Y_MAX) pix_y <= pix_y + YW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hcnt        <= '0;
      hs_seen     <= 1'b0;
      meas_htotal <= '0;
      run_len     <= '0;
      line_w      <= '0;
      line_cnt    <= '0;
      mism        <= 1'b0;
      skip_run    <= 1'b0;
      meas_width  <= '0;
      meas_height <= '0;
      frame_cnt   <= '0;
      err_geom    <= 1'b0;
    end else begin
      if (hs_lead) begin
        hcnt    <= XW'(1);
        hs_seen <= 1'b1;
        if (hs_seen) meas_htotal <= hcnt;
      end else if (hcnt != X_MAX) begin
        hcnt <= hcnt + XW'(1);
      end

      if (den_rise)                        run_len <= XW'(1);
      else if (den_s1 && run_len != X_MAX) run_len <= run_len + XW'(1);

      if (vs_lead) begin
        line_w   <= '0;
        line_cnt <= '0;
        mism     <= 1'b0;
        skip_run <= trunc;
      end else if (den_fall) begin
        skip_run <= 1'b0;
        if (!skip_run) begin
          line_w <= run_len;
          mism   <= mism | (run_len != meas_width);
          if (line_cnt != Y_MAX) line_cnt <= line_cnt + YW'(1);
        end
      end

      if (latch) begin
        meas_width  <= frame_w;
        meas_height <= frame_h;
        frame_cnt   <= frame_cnt + 16'd1;
      end
      if (set_err) err_geom <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lcd_capture.sv
// Directed bench for lcd_capture: synthetic 4x3 frames (htotal 8, 5 lines)
// with every output pixel checked against the generated stream two clocks later.
module tb_lcd_capture;
  import lcd_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic [7:0]  lcd_dat = 8'h00;
  logic        lcd_hsync = 1'b1;
  logic        lcd_vsync = 1'b1;
  logic        lcd_den = 1'b0;
  logic [7:0]  pix_dat;
  logic        pix_valid, pix_sof, pix_eol, locked, err_geom;
  logic [10:0] pix_x, meas_width, meas_htotal;
  logic [9:0]  pix_y, meas_height;
  logic [15:0] frame_cnt;

  int checkCount = 0;
  int passCount  = 0;

  typedef struct packed {
    logic        valid;
    logic        sof;
    logic        eol;
    logic [7:0]  dat;
    logic [10:0] x;
    logic [9:0]  y;
  } exp_t;

  exp_t hist [2];
  bit   capturing = 1'b0;
  bit   vs_drv = 1'b0;

  lcd_capture dut (
    .clk        (clk),
    .resetn     (resetn),
    .lcd_dat    (lcd_dat),
    .lcd_hsync  (lcd_hsync),
    .lcd_vsync  (lcd_vsync),
    .lcd_den    (lcd_den),
    .pix_dat    (pix_dat),
    .pix_valid  (pix_valid),
    .pix_sof    (pix_sof),
    .pix_eol    (pix_eol),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .meas_width (meas_width),
    .meas_height(meas_height),
    .meas_htotal(meas_htotal),
    .locked     (locked),
    .err_geom   (err_geom),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    else
      passCount++;
  endtask

  // One pixel clock: compare outputs with the pixel driven two clocks ago, then drive the next.
  task automatic applyStimulus(input bit vs, input bit hs, input bit den, input int x, input int y,
                               input bit sof, input bit eol);
    @(negedge clk);
    checkOutput("pix_valid", pix_valid, hist[1].valid);
    checkOutput("pix_sof", pix_sof, hist[1].sof);
    checkOutput("pix_eol", pix_eol, hist[1].eol);
    if (hist[1].valid) begin
      checkOutput("pix_dat", pix_dat, hist[1].dat);
      checkOutput("pix_x", pix_x, hist[1].x);
      checkOutput("pix_y", pix_y, hist[1].y);
    end
    hist[1] = hist[0];
    if (vs && !vs_drv) capturing = 1'b1;
    vs_drv        = vs;
    hist[0].valid = den & capturing;
    hist[0].sof   = sof & den & capturing;
    hist[0].eol   = eol & den & capturing;
    hist[0].dat   = den ? 8'(x + 16 * y) : 8'h00;
    hist[0].x     = 11'(x);
    hist[0].y     = 10'(y);
    lcd_vsync = ~vs;
    lcd_hsync = ~hs;
    lcd_den   = den;
    lcd_dat   = den ? 8'(x + 16 * y) : 8'h00;
  endtask

  task automatic send_line(input bit vs, input int den_start, input int den_len, input int y, input bit first);
    bit d;
    int x;
    for (int c = 0; c < H_TOTAL; c++) begin
      d = (c >= den_start) && (c < den_start + den_len);
      x = c - den_start;
      applyStimulus(vs, c == 0, d, x, y, first && x == 0, x == den_len - 1);
    end
  endtask

  // Three active lines, one blank line, then the vsync line that closes the frame.
  task automatic send_frame(input int last_len);
    for (int y = 0; y < V_ACTIVE; y++)
      send_line(1'b0, 2, (y == V_ACTIVE - 1) ? last_len : H_ACTIVE, y, y == 0);
    send_line(1'b0, 0, 0, 0, 1'b0);
    send_line(1'b1, 0, 0, 0, 1'b0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    resetn = 1'b0;
    #1;
    checkOutput("rst_pix_dat", pix_dat, 0);
    checkOutput("rst_pix_valid", pix_valid, 0);
    checkOutput("rst_pix_sof", pix_sof, 0);
    checkOutput("rst_pix_eol", pix_eol, 0);
    checkOutput("rst_pix_x", pix_x, 0);
    checkOutput("rst_pix_y", pix_y, 0);
    checkOutput("rst_meas_width", meas_width, 0);
    checkOutput("rst_meas_height", meas_height, 0);
    checkOutput("rst_meas_htotal", meas_htotal, 0);
    checkOutput("rst_locked", locked, 0);
    checkOutput("rst_err_geom", err_geom, 0);
    checkOutput("rst_frame_cnt", frame_cnt, 0);
    hist[0]   = '0;
    hist[1]   = '0;
    capturing = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checkOutput("rst_hold_valid", pix_valid, 0);
      checkOutput("rst_hold_dat", pix_dat, 0);
    end
    resetn = 1'b1;
  endtask

  task automatic check_geom(input string tag, input int w, input int h, input bit lk, input bit err, input int cnt);
    checkOutput({tag, "_width"}, meas_width, w);
    checkOutput({tag, "_height"}, meas_height, h);
    checkOutput({tag, "_locked"}, locked, lk);
    checkOutput({tag, "_err"}, err_geom, err);
    checkOutput({tag, "_frame_cnt"}, frame_cnt, cnt);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    hist[0] = '0;
    hist[1] = '0;
    pulse_reset();

    repeat (125) send_line(1'b0, 0, 0, 0, 1'b0);
    checkOutput("idle_locked", locked, 0);
    checkOutput("idle_frame_cnt", frame_cnt, 0);

    // First vsync only leaves SEARCH; each later vsync closes and counts a frame.
    send_line(1'b1, 0, 0, 0, 1'b0);
    send_frame(H_ACTIVE);
    check_geom("f1", 4, 3, 1'b0, 1'b0, 1);
    send_frame(H_ACTIVE);
    check_geom("f2", 4, 3, 1'b1, 1'b0, 2);
    send_frame(H_ACTIVE);
    check_geom("f3", 4, 3, 1'b1, 1'b0, 3);
    checkOutput("f3_htotal", meas_htotal, H_TOTAL);

    send_frame(3);
    check_geom("short", 3, 3, 1'b0, 1'b1, 4);
    send_frame(H_ACTIVE);
    check_geom("clean1", 4, 3, 1'b0, 1'b1, 5);
    send_frame(H_ACTIVE);
    check_geom("clean2", 4, 3, 1'b1, 1'b1, 6);

    send_line(1'b0, 0, 0, 0, 1'b0);
    send_line(1'b1, 0, H_ACTIVE, 0, 1'b1);
    send_line(1'b0, 2, H_ACTIVE, 1, 1'b0);
    send_line(1'b0, 0, 0, 0, 1'b0);

    for (int c = 0; c < 4; c++)
      applyStimulus(1'b0, c == 0, c >= 2, c - 2, 1, 1'b0, 1'b0);
    pulse_reset();
    for (int c = 4; c < H_TOTAL; c++)
      applyStimulus(1'b0, 1'b0, c < 6, c - 2, 1, 1'b0, c == 5);
    send_line(1'b0, 2, H_ACTIVE, 1, 1'b0);
    send_line(1'b0, 2, H_ACTIVE, 2, 1'b0);
    send_line(1'b1, 0, 0, 0, 1'b0);
    send_line(1'b0, 2, H_ACTIVE, 0, 1'b1);
    send_line(1'b0, 0, 0, 0, 1'b0);
    check_geom("post_rst", 0, 0, 1'b0, 1'b0, 0);
    checkOutput("post_rst_htotal", meas_htotal, H_TOTAL);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
